// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter.
// CPU stores to TX_ADDR queue a byte in a small FIFO. The serializer sends
// each byte as 8N1, LSB first, at CLKS_PER_BIT clocks per bit, with no gap
// between frames. A store to STAT_ADDR clears the sticky overflow flag.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] TX_ADDR      = 32'h02000008,
    parameter logic [31:0] STAT_ADDR    = 32'h0200000C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        tx,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic        busy,
    output logic        overflow
);

    localparam int                PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [15:0]       BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic push_req, push, drop, stat_wr, pop;
    logic unused_wrdata;

    // Only the low byte of the store data is transmitted.
    assign unused_wrdata = ^Mem_WrData[31:8];

    assign push_req   = MemWrite && (Mem_WrAddr == TX_ADDR);
    assign push       = push_req && !fifo_full;
    assign drop       = push_req && fifo_full;
    assign stat_wr    = MemWrite && (Mem_WrAddr == STAT_ADDR);

    assign fifo_full  = (count_q == DEPTH_CNT);
    assign fifo_empty = (count_q == '0);
    assign busy       = (state_q != S_IDLE);
    assign overflow   = overflow_q;
    assign tx         = tx_q;
    assign rd_data    = (rd_addr == STAT_ADDR) ?
                        {28'b0, overflow_q, busy, fifo_full, fifo_empty} : 32'b0;

    // FIFO storage; entries are plain data and need no reset.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[tail_q] <= Mem_WrData[7:0];
        end
    end

    // FIFO pointers, occupancy count and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) tail_q <= tail_q + PTR_ONE;
            if (pop)  head_q <= head_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            // A drop is checked against the pre-edge full flag, so a pop in
            // the same cycle does not rescue the byte.
            if (stat_wr)   overflow_q <= 1'b0;
            else if (drop) overflow_q <= 1'b1;
        end
    end

    // Serializer next-state logic; tx is derived from the next state so the
    // registered line lines up with the state register.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[head_q];
                    state_d = S_START;
                    baud_d  = '0;
                end
            end
            S_START: begin
                if (baud_q == BAUD_LAST) begin
                    state_d   = S_DATA;
                    baud_d    = '0;
                    bit_idx_d = '0;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d    = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[head_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Serializer control state and the registered serial line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
        end
    end

    // Shift register holds frame data only, so it carries no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8: transmit FIFO entries; a power of two, 2..64.
REQ-003 The block SHALL have parameter TX_ADDR, default 32'h02000008: the CPU store address that pushes a byte.
REQ-004 The block SHALL have parameter STAT_ADDR, default 32'h0200000C: the status register address.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 Ports SHALL be as follows:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- MemWrite  in  1  CPU store strobe, single cycle per store
- Mem_WrAddr  in  32  CPU store address
- Mem_WrData  in  32  CPU store data; bits [7:0] are used
- rd_addr  in  32  CPU load address
- rd_data  out  32  status read data, combinational
- tx  out  1  serial line, idle high, registered
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- fifo_empty  out  1  FIFO holds 0 entries
- busy  out  1  serializer not in IDLE
- overflow  out  1  sticky: a byte was dropped

Function
REQ-007 A push SHALL occur on a rising edge where MemWrite=1, Mem_WrAddr==TX_ADDR and fifo_full=0; Mem_WrData[7:0] is written at the tail.
REQ-008 If MemWrite=1, Mem_WrAddr==TX_ADDR and fifo_full=1, the byte SHALL be dropped and overflow set, even if a pop occurs in the same cycle.
REQ-009 If MemWrite=1 and Mem_WrAddr==STAT_ADDR, overflow SHALL be cleared; a set caused by a push in the same cycle is impossible, because the address differs.
REQ-010 Stores to any other address SHALL have no effect.
REQ-011 The FIFO SHALL use wrapping head/tail pointers and a count of 0..FIFO_DEPTH; fifo_full and fifo_empty SHALL be decoded from count.
REQ-012 A simultaneous push and pop SHALL leave count unchanged and is legal whenever the FIFO is not full.
REQ-013 rd_data SHALL equal {28'b0, overflow, busy, fifo_full, fifo_empty} when rd_addr==STAT_ADDR; otherwise it SHALL be 0.
REQ-014 The serializer FSM SHALL have states IDLE, START, DATA and STOP, plus a baud counter, a 3-bit bit index and an 8-bit shift register.
REQ-015 In IDLE with fifo_empty=0, the FSM SHALL, on the next edge:
- pop the head entry into the shift register
- enter START
- zero the baud counter.
REQ-016 In START, tx SHALL be 0 for CLKS_PER_BIT cycles, after which the FSM enters DATA with bit index 0.
REQ-017 In DATA, tx SHALL equal shift[0] (LSB first) for CLKS_PER_BIT cycles per bit.
- The shift register then shifts right and the bit index increments.
- After bit index 7, the FSM enters STOP.
REQ-018 In STOP, tx SHALL be 1 for CLKS_PER_BIT cycles.
- Then, if fifo_empty=0, the FSM pops and enters START directly, with no idle bit.
- Otherwise it enters IDLE.
REQ-019 One frame SHALL last exactly 10*CLKS_PER_BIT cycles; back-to-back frames SHALL have no gap.
REQ-020 A write presented in cycle N to an empty FIFO with FSM in IDLE SHALL produce tx=0 starting after the edge ending cycle N+1, i.e. a latency of 2 edges.
REQ-021 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-022 The tx output SHALL be driven from a flop, with no combinational path from inputs.

Reset
REQ-023 While reset=1 at a rising edge, the block SHALL set:
- FSM to IDLE, tx=1
- count=0 and pointers=0, so fifo_empty=1 and fifo_full=0
- busy=0, overflow=0, baud counter=0, bit index=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame and discard FIFO contents; tx=1 on the edge after reset.
REQ-025 Stores during reset SHALL be ignored.

Verification
REQ-026 Single byte, CLKS_PER_BIT=4: store 0x000000A5 to 0x02000008 -> tx bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles; busy=0 and fifo_empty=1 afterwards.
REQ-027 Back-to-back: store 0x55 then 0x0F in consecutive cycles -> two frames of 40 cycles each with no idle between; busy high continuously for 80 cycles.
REQ-028 Overflow, FIFO_DEPTH=8:
- 10 consecutive stores while the first frame is in progress -> first byte popped, 8 queued, last byte dropped.
- rd_data at 0x0200000C reads 0x0000000E (overflow, busy, full).
- A store to 0x0200000C then clears bit 3.
REQ-029 Address filter: store to 0x02000004 and load from 0x02000008 -> no FIFO change, tx stays 1, rd_data=0.
REQ-030 Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued -> the next cycle gives tx=1, busy=0, fifo_empty=1, and no further frames.
REQ-031 Push/pop same cycle: store arrives on the STOP-to-START pop edge with count=1 -> count stays 1 and the byte is transmitted in order.
